// File: rtl/uno_seq.sv
// Job sequencer for the polynomial/MAC processing element: accepts one job at a time,
// issues its operand cycles with coefficient addressing, waits out the PE latency and hands off the result.
module uno_seq #(
    parameter int NTERMS  = 4,
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_valid,
    output logic                          start_ready,
    input  logic [1:0]                    op_in,
    input  logic [LEN_W-1:0]              len_in,
    input  logic                          abort,
    output logic [1:0]                    op,
    output logic                          fisrt_cycle,
    output logic                          last_cycle,
    output logic                          acc_en,
    output logic                          issue,
    output logic [$clog2(NTERMS)+1:0]     coeff_addr,
    output logic                          busy,
    output logic                          result_valid,
    input  logic                          result_ready
);

    localparam int IDX_W  = $clog2(NTERMS);
    localparam int DCNT_W = (MAC_LAT > 2) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_nxt;
    logic [LEN_W-1:0]   r_k;
    logic [LEN_W-1:0]   r_tlast;
    logic [DCNT_W-1:0]  r_dcnt;
    logic [1:0]         r_op;
    logic               w_accept;
    logic               w_last;
    logic [IDX_W-1:0]   w_idx;
    logic [LEN_W-1:0]   w_tlast_in;

    // Store T-1 so the last-cycle test is a plain equality; len 0 on MAC behaves as len 1.
    always_comb begin
        w_tlast_in = LEN_W'(NTERMS);
        if (op_in == 2'b00) begin
            w_tlast_in = (len_in == '0) ? '0 : (len_in - LEN_W'(1));
        end
    end

    assign w_last = (r_k == r_tlast);

    always_comb begin
        w_nxt        = r_state;
        w_accept     = 1'b0;
        start_ready  = 1'b0;
        busy         = 1'b1;
        result_valid = 1'b0;
        issue        = 1'b0;
        fisrt_cycle  = 1'b0;
        last_cycle   = 1'b0;
        acc_en       = 1'b0;
        w_idx        = '0;
        case (r_state)
            S_IDLE: begin
                busy        = 1'b0;
                start_ready = 1'b1;
                if (!abort && start_valid) begin
                    w_accept = 1'b1;
                    w_nxt    = S_RUN;
                end
            end
            S_RUN: begin
                issue       = 1'b1;
                fisrt_cycle = (r_k == '0);
                last_cycle  = w_last;
                acc_en      = (r_op == 2'b00) && (r_k != '0);
                // Horner steps past the last coefficient keep reusing the final term.
                if (r_k >= LEN_W'(NTERMS - 1)) begin
                    w_idx = IDX_W'(NTERMS - 1);
                end else begin
                    w_idx = r_k[IDX_W-1:0];
                end
                if (abort) begin
                    w_nxt = S_IDLE;
                end else if (w_last) begin
                    w_nxt = (MAC_LAT > 0) ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    w_nxt = S_IDLE;
                end else if (r_dcnt == DCNT_W'(MAC_LAT - 1)) begin
                    w_nxt = S_DONE;
                end
            end
            S_DONE: begin
                result_valid = 1'b1;
                if (abort || result_ready) begin
                    w_nxt = S_IDLE;
                end
            end
            default: begin
                w_nxt = S_IDLE;
            end
        endcase
    end

    assign op         = r_op;
    assign coeff_addr = {r_op, w_idx};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_dcnt  <= '0;
            r_op    <= 2'b00;
            r_tlast <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_accept) begin
                r_op    <= op_in;
                r_tlast <= w_tlast_in;
            end
            // Counters sit at zero outside their own state so each entry starts clean.
            r_k    <= (r_state == S_RUN && w_nxt == S_RUN) ? (r_k + LEN_W'(1)) : '0;
            r_dcnt <= (r_state == S_DRAIN && w_nxt == S_DRAIN) ? (r_dcnt + DCNT_W'(1)) : '0;
        end
    end

endmodule

// File: doc/uno_seq.md
UNO_SEQ -- requirements
Module: uno_seq

Interface
REQ-001 Parameter NTERMS, default 4: number of polynomial coefficients per non-MAC op; power of two, 2..16.
REQ-002 Parameter LEN_W, default 8: width of the MAC length field and of the cycle counter.
REQ-003 Parameter MAC_LAT, default 1: cycles from the last issue until the MAC result is registered.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start_valid  in  1  a job request is present.
REQ-007 start_ready  out  1  block accepts a job; high only in IDLE.
REQ-008 op_in  in  2  job op: 00 MAC, 01 div, 10 exp, 11 log.
REQ-009 len_in  in  LEN_W  MAC accumulation count; ignored for non-MAC ops.
REQ-010 abort  in  1  synchronous job cancel.
REQ-011 op  out  2  latched job op, driven to the PE.
REQ-012 fisrt_cycle  out  1  first issue cycle of the job; port spelled exactly as in the PE.
REQ-013 last_cycle  out  1  final issue cycle of the job.
REQ-014 acc_en  out  1  PE accumulates onto its previous result.
REQ-015 issue  out  1  operand strobe; upstream presents X/Y/Z during this cycle.
REQ-016 coeff_addr  out  2+log2(NTERMS)  coefficient ROM address, {op, term index}.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 result_valid  out  1  PE output holds the final job result.
REQ-019 result_ready  in  1  consumer takes the result.

Function
REQ-020 States are IDLE, RUN, DRAIN and DONE; encoding is free.
REQ-021 A job is accepted on an edge where start_valid=1 and start_ready=1; op_in and len_in are latched on that edge and the state goes IDLE->RUN.
REQ-022 T (issue count) = max(len_in,1) for MAC, and NTERMS+1 for div/exp/log (NTERMS Horner steps plus one scale/offset step).
REQ-023 Counter k = 0 on RUN entry; it increments once per RUN cycle; RUN lasts exactly T cycles.
REQ-024 In RUN: issue=1; fisrt_cycle=(k==0); last_cycle=(k==T-1); both are 1 when T=1.
REQ-025 acc_en = (op==00) && (k!=0) in RUN; 0 in all other states.
REQ-026 coeff_addr = {op, min(k,NTERMS-1)} in RUN; {op, 0} otherwise.
REQ-027 On the cycle with k==T-1, RUN->DRAIN; DRAIN lasts MAC_LAT cycles, then DRAIN->DONE.
REQ-028 In DONE, result_valid=1 until an edge with result_ready=1, then DONE->IDLE; a new job can be accepted on the following cycle.
REQ-029 Latency: result_valid rises T+MAC_LAT cycles after the accept edge.
REQ-030 Outside RUN, op keeps the last latched value and issue, fisrt_cycle and last_cycle are 0.
REQ-031 start_valid while busy is ignored (start_ready=0); the request is not queued.
REQ-032 abort=1 in any state forces IDLE on the next edge and asserts no result_valid for that job; abort with start_valid in IDLE takes priority and no job is accepted.
REQ-033 len_in=0 on a MAC job behaves exactly as len_in=1.
REQ-034 Counter width is LEN_W, so the maximum MAC length is 2^LEN_W-1 with no wrap; NTERMS+1 <= 2^LEN_W-1 is required.

Reset
REQ-035 While rst_n=0, asynchronously: state=IDLE, k=0, op=00, start_ready=1, busy=0, result_valid=0, and issue, fisrt_cycle, last_cycle, acc_en=0, coeff_addr=0.
REQ-036 Reset asserted mid-job discards the job; after release the block is in IDLE and ready to accept.

Verification
REQ-037 MAC job, len_in=3 -> issue high 3 cycles; acc_en 0,1,1; fisrt_cycle on cycle 0; last_cycle on cycle 2; result_valid 4 cycles after accept.
REQ-038 exp job (op 10), NTERMS=4 -> 5 issue cycles; coeff_addr 8,9,10,11,11; last_cycle on the 5th; acc_en always 0.
REQ-039 MAC len_in=0 -> single issue with fisrt_cycle=last_cycle=1 and acc_en=0.
REQ-040 DONE with result_ready=0 for 3 cycles -> result_valid stays high and start_ready stays 0; result_ready=1 -> IDLE the next cycle.
REQ-041 abort on the 2nd RUN cycle of a log job -> IDLE next cycle; no result_valid; the next job runs normally.
REQ-042 rst_n low during DRAIN -> all outputs immediately at reset values; start_ready=1 after release.
